// File: rtl/gray_bits_packer_if.sv
// gray_bits_packer_if: input group stream and output word stream of the gray bits packer
interface gray_bits_packer_if #(
  parameter int BITS_IN   = 6,
  parameter int WIDTH_OUT = 8
);
  logic [BITS_IN-1:0]                 i_tdata;
  logic                               i_tlast;
  logic                               i_tvalid;
  logic                               i_tready;
  logic [WIDTH_OUT-1:0]               o_tdata;
  logic                               o_tlast;
  logic [$clog2(WIDTH_OUT+1)-1:0]     o_nbits;
  logic                               o_tvalid;
  logic                               o_tready;
  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_nbits, o_tvalid
  );
  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_nbits, o_tvalid
  );
endinterface

// File: rtl/gray_bits_packer.sv
// gray_bits_packer: packs BITS_IN-bit gray groups into WIDTH_OUT-bit words with zero-padded flush on tlast
module gray_bits_packer #(
  parameter int BITS_IN   = 6,
  parameter int WIDTH_OUT = 8,
  parameter int MSB_FIRST = 0
) (
  input logic              clk,
  input logic              reset,
  input logic              clear,
  gray_bits_packer_if.slave s
);
  localparam int T  = WIDTH_OUT + BITS_IN;
  localparam int NW = $clog2(T + 1);
  localparam int OW = $clog2(WIDTH_OUT + 1);
  localparam logic [NW-1:0] WN = NW'(WIDTH_OUT);
  localparam logic [NW-1:0] BN = NW'(BITS_IN);
  typedef enum logic {ACCUM, FLUSH} state_t;
  state_t               state, state_n;
  logic [T-1:0]         acc, acc_n, ins;
  logic [NW-1:0]        cnt, cnt_n, n;
  logic [WIDTH_OUT-1:0] tdata_n;
  logic [OW-1:0]        nbits_n;
  logic                 tlast_n, tvalid_n, ld, acc_ok;
  function automatic logic [WIDTH_OUT-1:0] word(input logic [T-1:0] x);
    return MSB_FIRST != 0 ? x[T-1:BITS_IN] : x[WIDTH_OUT-1:0];
  endfunction
  function automatic logic [T-1:0] resid(input logic [T-1:0] x);
    return MSB_FIRST != 0 ? x << WIDTH_OUT : x >> WIDTH_OUT;
  endfunction
  assign ld         = !s.o_tvalid || s.o_tready;
  assign s.i_tready = (state == ACCUM) && ld;
  assign acc_ok     = s.i_tvalid && s.i_tready;
  assign n          = cnt + BN;
  assign ins        = acc | (MSB_FIRST != 0 ? {s.i_tdata, {WIDTH_OUT{1'b0}}} >> cnt
                                            : {{WIDTH_OUT{1'b0}}, s.i_tdata} << cnt);
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    cnt_n    = cnt;
    tdata_n  = s.o_tdata;
    tlast_n  = s.o_tlast;
    nbits_n  = s.o_nbits;
    tvalid_n = s.o_tvalid && !s.o_tready;
    if (state == FLUSH && ld) begin
      tvalid_n = 1'b1;
      tdata_n  = word(acc);
      nbits_n  = OW'(cnt);
      tlast_n  = 1'b1;
      acc_n    = '0;
      cnt_n    = '0;
      state_n  = ACCUM;
    end else if (acc_ok) begin
      if (n < WN && !s.i_tlast) begin
        acc_n = ins;
        cnt_n = n;
      end else begin
        tvalid_n = 1'b1;
        tdata_n  = word(ins);
        nbits_n  = n <= WN ? OW'(n) : OW'(WN);
        tlast_n  = s.i_tlast && n <= WN;
        acc_n    = n > WN ? resid(ins) : '0;
        cnt_n    = n > WN ? n - WN : '0;
        state_n  = n > WN && s.i_tlast ? FLUSH : ACCUM;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state      <= ACCUM;
      acc        <= '0;
      cnt        <= '0;
      s.o_tdata  <= '0;
      s.o_tlast  <= 1'b0;
      s.o_nbits  <= '0;
      s.o_tvalid <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      s.o_tdata  <= tdata_n;
      s.o_tlast  <= tlast_n;
      s.o_nbits  <= nbits_n;
      s.o_tvalid <= tvalid_n;
    end
  end
endmodule
